// File: rtl/acia_rx_pkg.sv
// rtl/acia_rx_pkg.sv - shared ACIA receive definitions: bit-rate defaults and FSM encodings
package acia_rx_pkg;

  // Defaults shared with the transmit side: 9600bps from a 4MHz pclk
  localparam int ACIA_SCW     = 9;
  localparam int ACIA_SYM_CNT = 417;

  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_STOP  = 3'd3,
    RX_BREAK = 3'd4
  } rx_state_t;

endpackage

// File: rtl/acia_sync2.sv
// rtl/acia_sync2.sv - two-flop synchroniser with enable, resets to the idle-high level
module acia_sync2 (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic d,
  output logic q
);

  logic s1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= 1'b1;
      q  <= 1'b1;
    end else if (en) begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/acia_rx.sv
// rtl/acia_rx.sv - ACIA 8N1 serial receiver with one-deep holding register and status flags
module acia_rx
  import acia_rx_pkg::*;
#(
  parameter int SCW     = ACIA_SCW,
  parameter int sym_cnt = ACIA_SYM_CNT
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pclk,
  input  logic       rx_serial,
  input  logic       rx_ack,
  output logic [7:0] rx_dat,
  output logic       rx_full,
  output logic       rx_ferr,
  output logic       rx_oerr
);

  localparam logic [SCW-1:0] HALF = SCW'(sym_cnt >> 1);
  localparam logic [SCW-1:0] SYM  = SCW'(sym_cnt);

  rx_state_t      state, state_nxt;
  logic           rxs;
  logic [SCW-1:0] rcnt;
  logic [3:0]     bcnt;
  logic [7:0]     shreg;
  logic           cnt_zero;

  logic load_half, load_sym, rcnt_dec, clr_bcnt, shift_en, stop_tick;

  acia_sync2 u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (pclk),
    .d       (rx_serial),
    .q       (rxs)
  );

  assign cnt_zero = (rcnt == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= RX_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (pclk) begin
      case (state)
        RX_IDLE:  if (!rxs) state_nxt = RX_START;
        RX_START: if (cnt_zero) state_nxt = rxs ? RX_IDLE : RX_DATA;
        RX_DATA:  if (cnt_zero && bcnt == 4'd7) state_nxt = RX_STOP;
        RX_STOP:  if (cnt_zero) state_nxt = rxs ? RX_IDLE : RX_BREAK;
        RX_BREAK: if (rxs) state_nxt = RX_IDLE;
        default:  state_nxt = RX_IDLE;
      endcase
    end
  end

  always_comb begin
    load_half = 1'b0;
    load_sym  = 1'b0;
    rcnt_dec  = 1'b0;
    clr_bcnt  = 1'b0;
    shift_en  = 1'b0;
    stop_tick = 1'b0;
    if (pclk) begin
      case (state)
        RX_IDLE:  load_half = !rxs;
        RX_START: begin
          rcnt_dec = !cnt_zero;
          load_sym = cnt_zero && !rxs;
          clr_bcnt = cnt_zero && !rxs;
        end
        RX_DATA: begin
          rcnt_dec = !cnt_zero;
          shift_en = cnt_zero;
          load_sym = cnt_zero;
        end
        RX_STOP: begin
          rcnt_dec  = !cnt_zero;
          stop_tick = cnt_zero;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rcnt  <= '0;
      bcnt  <= '0;
      shreg <= '0;
    end else begin
      if (load_half)     rcnt <= HALF;
      else if (load_sym) rcnt <= SYM;
      else if (rcnt_dec) rcnt <= rcnt - SCW'(1);

      if (clr_bcnt)      bcnt <= '0;
      else if (shift_en) bcnt <= bcnt + 4'd1;

      // Line is LSB first, so each new bit enters at the top
      if (shift_en) shreg <= {rxs, shreg[7:1]};
    end
  end

  // An ack landing on the store edge frees the slot for the incoming byte
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_dat  <= '0;
      rx_full <= 1'b0;
      rx_ferr <= 1'b0;
      rx_oerr <= 1'b0;
    end else if (stop_tick) begin
      if (!rx_full || rx_ack) begin
        rx_dat  <= shreg;
        rx_full <= 1'b1;
        rx_ferr <= ~rxs;
      end else begin
        rx_oerr <= 1'b1;
      end
    end else if (rx_ack) begin
      rx_full <= 1'b0;
      rx_oerr <= 1'b0;
    end
  end

endmodule
